// File: rtl/motoro3_step_sequencer.sv
// Purpose: 12-step commutation sequencer feeding the 3-phase PWM generators (step index, step counter, strobes, ramped position target).
// Latency: start -> first step cycle (m3cntFirst2) after 1 falling clk edge; target/length updates land on step boundaries.
// Backpressure: none; start/stop are one-cycle requests, stop is held sticky until the 12-step cycle completes.
module motoro3_step_sequencer #(
  parameter int LAST_STEP    = 11,
  parameter int CNT_W        = 25,
  parameter int MIN_STEP_LEN = 4
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] m3r_stepLen,
  input  logic [15:0]      m3r_posWant,
  input  logic [15:0]      m3r_rampInc,
  input  logic [11:0]      m3r_pwmLenWant,
  output logic [3:0]       sgStep,
  output logic [CNT_W-1:0] m3cnt,
  output logic             m3cntFirst2,
  output logic             m3cntFirst1,
  output logic             m3cntLast2,
  output logic             m3cntLast1,
  output logic             pwmActive1,
  output logic             pwmLastStep1,
  output logic [15:0]      pwmLENpos,
  output logic             done,
  output logic             cfgErr
);

  typedef enum logic {IDLE, RUN} stateT;

  stateT            state;
  logic             stopPend;
  logic [CNT_W-1:0] lenL;
  logic             lenOk;
  logic             atBoundary;
  logic             haltNow;
  logic [15:0]      rampFromZero;
  logic [15:0]      rampFromCur;

  // Step one target toward min(posWant, pwmLenWant), limited by rampInc; 17-bit math avoids wrap.
  function automatic logic [15:0] rampFn(input logic [15:0] cur, input logic [15:0] want,
                                         input logic [11:0] lenWant, input logic [15:0] inc);
    logic [16:0] tgt;
    logic [16:0] curE;
    logic [16:0] incE;
    logic [16:0] diff;
    logic [16:0] res;
    tgt  = ({1'b0, want} < {5'd0, lenWant}) ? {1'b0, want} : {5'd0, lenWant};
    curE = {1'b0, cur};
    incE = {1'b0, inc};
    diff = (tgt >= curE) ? (tgt - curE) : (curE - tgt);
    if (inc == 16'd0 || diff <= incE) begin
      res = tgt;
    end else if (tgt > curE) begin
      res = curE + incE;
    end else begin
      res = curE - incE;
    end
    return res[15:0];
  endfunction

  assign lenOk        = (m3r_stepLen >= CNT_W'(MIN_STEP_LEN));
  assign atBoundary   = (m3cnt == '0);
  assign haltNow      = (sgStep == 4'(LAST_STEP)) && stopPend;
  assign rampFromZero = rampFn(16'd0, m3r_posWant, m3r_pwmLenWant, m3r_rampInc);
  assign rampFromCur  = rampFn(pwmLENpos, m3r_posWant, m3r_pwmLenWant, m3r_rampInc);

  // Position strobes and qualifiers decoded from registered state; forced low outside RUN.
  always_comb begin
    pwmActive1   = (state == RUN);
    m3cntFirst2  = pwmActive1 && (m3cnt == lenL - CNT_W'(1));
    m3cntFirst1  = pwmActive1 && (m3cnt == lenL - CNT_W'(2));
    m3cntLast2   = pwmActive1 && (m3cnt == CNT_W'(1));
    m3cntLast1   = pwmActive1 && atBoundary;
    pwmLastStep1 = pwmActive1 && haltNow;
  end

  // Sequencer FSM; all flops advance on the falling edge of clk.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      stopPend  <= 1'b0;
      lenL      <= '0;
      sgStep    <= 4'd0;
      m3cnt     <= '0;
      pwmLENpos <= 16'd0;
      done      <= 1'b0;
      cfgErr    <= 1'b0;
    end else begin
      done   <= 1'b0;
      cfgErr <= 1'b0;
      case (state)
        IDLE: begin
          // stop is meaningless here; a simultaneous start wins
          if (start) begin
            if (lenOk) begin
              state     <= RUN;
              lenL      <= m3r_stepLen;
              m3cnt     <= m3r_stepLen - CNT_W'(1);
              sgStep    <= 4'd0;
              pwmLENpos <= rampFromZero;
            end else begin
              cfgErr <= 1'b1;
            end
          end
        end
        RUN: begin
          // stopPend is sampled at the boundary before this cycle's stop lands,
          // so a stop on the very last cycle defers the halt by one full cycle
          if (stop) begin
            stopPend <= 1'b1;
          end
          if (atBoundary) begin
            if (haltNow) begin
              state     <= IDLE;
              done      <= 1'b1;
              stopPend  <= 1'b0;
              sgStep    <= 4'd0;
              m3cnt     <= '0;
              pwmLENpos <= 16'd0;
            end else begin
              sgStep    <= (sgStep == 4'(LAST_STEP)) ? 4'd0 : sgStep + 4'd1;
              pwmLENpos <= rampFromCur;
              if (lenOk) begin
                lenL  <= m3r_stepLen;
                m3cnt <= m3r_stepLen - CNT_W'(1);
              end else begin
                // bad length: keep running with the previous one and flag it
                cfgErr <= 1'b1;
                m3cnt  <= lenL - CNT_W'(1);
              end
            end
          end else begin
            m3cnt <= m3cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Bench for motoro3_step_sequencer: directed plan scenarios followed by random traffic.
// Expected values come from a step-position model (step index, cycle offset within step, ramped target).
// Inputs are driven just after the rising edge; the DUT advances on the falling edge; outputs compared after the rising edge.
module tb_motoro3_step_sequencer;

  logic        clk;
  logic        nRst;
  logic        start;
  logic        stop;
  logic [24:0] m3r_stepLen;
  logic [15:0] m3r_posWant;
  logic [15:0] m3r_rampInc;
  logic [11:0] m3r_pwmLenWant;
  logic [3:0]  sgStep;
  logic [24:0] m3cnt;
  logic        m3cntFirst2;
  logic        m3cntFirst1;
  logic        m3cntLast2;
  logic        m3cntLast1;
  logic        pwmActive1;
  logic        pwmLastStep1;
  logic [15:0] pwmLENpos;
  logic        done;
  logic        cfgErr;

  int checks;
  int failures;

  // reference model: running flag, step index, offset k counted up from step start
  bit mRun;
  int mStep;
  int mK;
  int mLen;
  int mPos;
  bit mPend;
  bit mDone;
  bit mErr;

  motoro3_step_sequencer dut (
    .clk(clk), .nRst(nRst), .start(start), .stop(stop),
    .m3r_stepLen(m3r_stepLen), .m3r_posWant(m3r_posWant),
    .m3r_rampInc(m3r_rampInc), .m3r_pwmLenWant(m3r_pwmLenWant),
    .sgStep(sgStep), .m3cnt(m3cnt),
    .m3cntFirst2(m3cntFirst2), .m3cntFirst1(m3cntFirst1),
    .m3cntLast2(m3cntLast2), .m3cntLast1(m3cntLast1),
    .pwmActive1(pwmActive1), .pwmLastStep1(pwmLastStep1),
    .pwmLENpos(pwmLENpos), .done(done), .cfgErr(cfgErr)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic chkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rampM(input int cur);
    int tgt;
    int d;
    tgt = (int'(m3r_posWant) < int'(m3r_pwmLenWant)) ? int'(m3r_posWant) : int'(m3r_pwmLenWant);
    d = (tgt > cur) ? tgt - cur : cur - tgt;
    if (m3r_rampInc == 0 || d <= int'(m3r_rampInc)) return tgt;
    return (tgt > cur) ? cur + int'(m3r_rampInc) : cur - int'(m3r_rampInc);
  endfunction

  task automatic mdlReset();
    mRun = 0; mStep = 0; mK = 0; mLen = 0; mPos = 0; mPend = 0; mDone = 0; mErr = 0;
  endtask

  // advance model by one clock using the inputs as currently driven
  task automatic mdlStep();
    bit stopNow;
    stopNow = stop;
    mDone = 0;
    mErr = 0;
    if (!mRun) begin
      if (start) begin
        if (m3r_stepLen >= 4) begin
          mRun = 1; mStep = 0; mK = 0; mLen = int'(m3r_stepLen); mPos = rampM(0);
        end else begin
          mErr = 1;
        end
      end
    end else if (mK == mLen - 1) begin
      if (mStep == 11 && mPend) begin
        mRun = 0; mStep = 0; mK = 0; mPos = 0; mPend = 0; mDone = 1;
      end else begin
        mPend = mPend | stopNow;
        mStep = (mStep + 1) % 12;
        mK = 0;
        mPos = rampM(mPos);
        if (m3r_stepLen >= 4) mLen = int'(m3r_stepLen);
        else mErr = 1;
      end
    end else begin
      mPend = mPend | stopNow;
      mK++;
    end
  endtask

  task automatic compareAll();
    chkVal("pwmActive1", 32'(pwmActive1), 32'(mRun));
    chkVal("sgStep", 32'(sgStep), 32'(mStep));
    chkVal("m3cnt", 32'(m3cnt), mRun ? 32'(mLen - 1 - mK) : 32'd0);
    chkVal("first2", 32'(m3cntFirst2), 32'(mRun && mK == 0));
    chkVal("first1", 32'(m3cntFirst1), 32'(mRun && mK == 1));
    chkVal("last2", 32'(m3cntLast2), 32'(mRun && mK == mLen - 2));
    chkVal("last1", 32'(m3cntLast1), 32'(mRun && mK == mLen - 1));
    chkVal("lastStep", 32'(pwmLastStep1), 32'(mRun && mPend && mStep == 11));
    chkVal("pwmLENpos", 32'(pwmLENpos), 32'(mPos));
    chkVal("done", 32'(done), 32'(mDone));
    chkVal("cfgErr", 32'(cfgErr), 32'(mErr));
  endtask

  task automatic tick();
    mdlStep();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic pulseStart();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulseStop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic runUntilIdle(input int limit);
    int n;
    n = 0;
    while (mRun && n < limit) begin
      tick();
      n++;
    end
    if (mRun) chkVal("haltTimeout", 32'(pwmActive1), 32'd0);
  endtask

  task automatic setCfg(input int len, input int want, input int inc, input int pwmLen);
    m3r_stepLen = 25'(len); m3r_posWant = 16'(want); m3r_rampInc = 16'(inc); m3r_pwmLenWant = 12'(pwmLen);
  endtask

  int rampUp[6] = '{64, 128, 192, 256, 300, 300};
  int rampDn[4] = '{236, 172, 108, 100};

  initial begin
    checks = 0;
    failures = 0;
    nRst = 1'b0; start = 1'b0; stop = 1'b0;
    setCfg(8, 100, 0, 511);
    mdlReset();
    #10;
    compareAll();
    @(posedge clk);
    #1;
    nRst = 1'b1;

    // basic stepping, full wrap 11 -> 0, then clamp to pwmLenWant
    pulseStart();
    ticks(100);
    m3r_posWant = 16'd600;
    ticks(20);
    chkVal("clamp", 32'(pwmLENpos), 32'd511);
    // stop during step 4, run through step 11 and halt
    while (mStep != 4) tick();
    pulseStop();
    runUntilIdle(200);
    ticks(3);

    // ramp up then down
    setCfg(8, 300, 64, 511);
    pulseStart();
    for (int i = 0; i < 6; i++) begin
      chkVal("rampUp", 32'(pwmLENpos), 32'(rampUp[i]));
      ticks(8);
    end
    m3r_posWant = 16'd100;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) ticks(8);
      else ticks(8 - 6 * 0);
      chkVal("rampDn", 32'(pwmLENpos), 32'(rampDn[i]));
    end

    // bad length mid-run, ignored start while running, stop on last cycle of step 11
    m3r_stepLen = 25'd2;
    ticks(20);
    pulseStart();
    m3r_stepLen = 25'd8;
    while (!(mStep == 11 && mK == mLen - 1)) tick();
    pulseStop();
    runUntilIdle(200);

    // bad length on start
    m3r_stepLen = 25'd3;
    pulseStart();
    chkVal("startErr", 32'(cfgErr), 32'd1);
    ticks(4);
    // start and stop together in IDLE
    m3r_stepLen = 25'd8;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;

    // async reset mid step 7 with m3cnt == 3
    for (int n = 0; n < 200 && !(mStep == 7 && mK == 4); n++) tick();
    nRst = 1'b0;
    #1;
    mdlReset();
    compareAll();
    @(posedge clk);
    #1;
    compareAll();
    nRst = 1'b1;
    ticks(20);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 30) == 0) m3r_stepLen = 25'($urandom_range(2, 12));
      if ($urandom_range(0, 40) == 0) m3r_posWant = 16'($urandom_range(0, 4500));
      if ($urandom_range(0, 40) == 0) m3r_rampInc = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 400));
      if ($urandom_range(0, 60) == 0) m3r_pwmLenWant = 12'($urandom_range(0, 4095));
      start = ($urandom_range(0, 40) == 0);
      stop  = ($urandom_range(0, 150) == 0);
      tick();
      start = 1'b0;
      stop  = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motoro3_step_sequencer.md
Name: motoro3_step_sequencer

Overview:
- Sequences the 3-phase PWM generator: produces the 12-step commutation index, the per-step position counter and its first/last strobes, the active/last-step qualifiers and the per-step PWM position target.
- Ramps the target between steps.
- Sits between the register file (m3r_* settings) and the PWM generator instances.
- Handles start/stop of the step cycle.

Parameters:
- LAST_STEP, 11, index of final commutation step; sgStep wraps LAST_STEP -> 0.
- CNT_W, 25, width of m3cnt and m3r_stepLen.
- MIN_STEP_LEN, 4, smallest accepted step length in clk cycles.

Ports:
- clk  input  1  system clock, 10 MHz; all flops update on falling edge of clk (codebase convention).
- nRst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin stepping.
- stop  input  1  one-cycle request to finish the current 12-step cycle and halt.
- m3r_stepLen  input  25  clk cycles per step.
- m3r_posWant  input  16  target PWM position (on-cycles per PWM period).
- m3r_rampInc  input  16  max change of pwmLENpos per step boundary; 0 = no ramp.
- m3r_pwmLenWant  input  12  PWM period, used as upper clamp of target.
- sgStep  output  4  current step 0..11.
- m3cnt  output  25  down-counter within step.
- m3cntFirst2  output  1  first cycle of step.
- m3cntFirst1  output  1  second cycle of step.
- m3cntLast2  output  1  next-to-last cycle of step.
- m3cntLast1  output  1  last cycle of step.
- pwmActive1  output  1  high while sequencing.
- pwmLastStep1  output  1  high during final step before halt.
- pwmLENpos  output  16  per-step position target, stable within a step.
- done  output  1  one-cycle pulse on halt.
- cfgErr  output  1  one-cycle pulse on rejected start.

Behaviour:
Reset values (async, any time including mid-run):
- state = IDLE.
- sgStep = 0, m3cnt = 0, all strobes 0, pwmActive1 = 0, pwmLastStep1 = 0.
- pwmLENpos = 0, done = 0, cfgErr = 0, stopPend = 0.
- No partial step is completed after reset.

States: IDLE, RUN.

IDLE:
- All outputs at reset values, except done/cfgErr, which may be pulsing.
- start with m3r_stepLen >= MIN_STEP_LEN: next edge enters RUN and performs a step load.
- Step load: latch stepLen into lenL, set m3cnt = stepLen-1, sgStep = 0, pwmLENpos = ramp(0).
- start with m3r_stepLen < MIN_STEP_LEN: stay IDLE, cfgErr = 1 for one cycle.
- stop in IDLE is ignored. start and stop together in IDLE: start is honoured, stop is dropped.

RUN:
- pwmActive1 = 1.
- m3cnt decrements by 1 each cycle.
- Strobes are combinational decodes of registered values (one-hot, never overlapping since lenL >= 4):
  - m3cntFirst2 = (m3cnt == lenL-1).
  - m3cntFirst1 = (m3cnt == lenL-2).
  - m3cntLast2 = (m3cnt == 1).
  - m3cntLast1 = (m3cnt == 0).
- At m3cnt == 0 (step boundary):
  - If sgStep == LAST_STEP and stopPend: enter IDLE, done = 1 next cycle, stopPend cleared.
  - Otherwise: sgStep = (sgStep == LAST_STEP) ? 0 : sgStep+1; relatch lenL from m3r_stepLen and reload m3cnt = lenL-1; update pwmLENpos = ramp(pwmLENpos).
  - If the new m3r_stepLen < MIN_STEP_LEN, keep the old lenL and pulse cfgErr.
- stop in RUN sets sticky stopPend. A second stop has no effect. A start in RUN is ignored.
- stop arriving on the last cycle of step LAST_STEP takes effect at the end of the next cycle's step 11, not the current one.
- pwmLastStep1 = RUN && stopPend && sgStep == LAST_STEP.

Ramp function:
- tgt = min(m3r_posWant, {4'd0, m3r_pwmLenWant}).
- If m3r_rampInc == 0 or |tgt - cur| <= m3r_rampInc: result = tgt.
- Otherwise: result = cur ± m3r_rampInc toward tgt.
- Arithmetic uses 17 bits internally, so there is no wrap-around and no overshoot.

Latency and timing:
- Start to m3cntFirst2: 1 clk edge.
- sgStep, pwmLENpos and lenL change only at step boundaries. Register changes mid-step take effect at the next boundary.
- m3cnt wrap: never below 0; always reloaded at 0.

Test Plan:
1. Reset then start, stepLen=8, posWant=100, rampInc=0, pwmLenWant=511 -> pwmActive1=1, sgStep 0 with m3cnt 7..0; First2@7, First1@6, Last2@1, Last1@0; pwmLENpos=100; after 96 cycles sgStep wraps 11->0.
2. Ramp: posWant=300, rampInc=64 from 0 -> pwmLENpos per step 64,128,192,256,300,300. Then posWant=100 -> 236,172,108,100.
3. Clamp: posWant=600, pwmLenWant=511, rampInc=0 -> pwmLENpos=511.
4. stop during step 4 -> stopPend; steps continue to 11; pwmLastStep1 high for all 8 cycles of step 11; then IDLE, done one pulse, sgStep=0, pwmLENpos=0.
5. start with stepLen=3 -> cfgErr pulse, stays IDLE. In RUN, stepLen changed to 2 -> cfgErr at boundary, step length stays 8. start while RUN is ignored.
6. nRst low mid-step 7, m3cnt=3 -> all outputs immediately at reset values. After release, no activity until start.
